// File: rtl/fpaddsub_stream_ctrl_if.sv
// rtl/fpaddsub_stream_ctrl_if.sv - operand, core and result signal bundle for the FP add/sub stream controller
interface fpaddsub_stream_ctrl_if #(
  parameter int TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic            in_op;
  logic [TAGW-1:0] in_tag;

  logic [31:0]     core_a;
  logic [31:0]     core_b;
  logic            core_ctrl;
  logic            core_rst;
  logic [31:0]     core_z;
  logic [4:0]      core_flags;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_z;
  logic [4:0]      out_flags;
  logic [TAGW-1:0] out_tag;

  // Controller side
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, core_z, core_flags, out_ready,
    output in_ready, core_a, core_b, core_ctrl, core_rst, out_valid, out_z, out_flags, out_tag
  );

  // Producer, consumer and core side
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, core_z, core_flags, out_ready,
    input  in_ready, core_a, core_b, core_ctrl, core_rst, out_valid, out_z, out_flags, out_tag
  );
endinterface

// File: rtl/fpaddsub_stream_ctrl.sv
// rtl/fpaddsub_stream_ctrl.sv - valid/ready front-end and in-order result collector for the FP add/sub core
// Credits cap outstanding operations at DEPTH so every core result is guaranteed a FIFO slot.
module fpaddsub_stream_ctrl #(
  parameter int LAT   = 11,
  parameter int DEPTH = 16,
  parameter int TAGW  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fpaddsub_stream_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAGW + 37;

  logic            issue;
  logic            pop;
  logic            push;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [DEPTH];

  logic [LAT:0]    trk_v;
  logic [TAGW-1:0] trk_tag [LAT+1];

  logic [31:0]     core_a_q;
  logic [31:0]     core_b_q;
  logic            core_ctrl_q;

  assign issue = bus.in_valid & bus.in_ready;
  assign pop   = bus.out_valid & bus.out_ready;
  assign push  = trk_v[LAT];

  assign bus.in_ready  = (outstanding < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.core_rst  = ~rst_n;
  assign bus.core_a    = core_a_q;
  assign bus.core_b    = core_b_q;
  assign bus.core_ctrl = core_ctrl_q;

  // Storage is not reset, so the head entry is masked whenever the FIFO is empty.
  always_comb begin
    {bus.out_tag, bus.out_flags, bus.out_z} = '0;
    if (count != '0) begin
      {bus.out_tag, bus.out_flags, bus.out_z} = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_ctrl_q <= 1'b0;
    end else if (issue) begin
      core_a_q    <= bus.in_a;
      core_b_q    <= bus.in_b;
      core_ctrl_q <= bus.in_op;
    end
  end

  // One stage per cycle of core latency plus the operand register in front of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk_v <= '0;
    end else begin
      trk_v <= {trk_v[LAT-1:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    trk_tag[0] <= bus.in_tag;
    for (int i = 1; i <= LAT; i++) begin
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {trk_tag[LAT], bus.core_flags, bus.core_z};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_fpaddsub_stream_ctrl.sv
// tb/tb_fpaddsub_stream_ctrl.sv - self-checking bench for fpaddsub_stream_ctrl with a behavioural FP core
module tb_fpaddsub_stream_ctrl;
  localparam int LAT   = 11;
  localparam int DEPTH = 16;
  localparam int TAGW  = 4;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [31:0]     z;
    logic [4:0]      flags;
    int              cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpaddsub_stream_ctrl_if #(.TAGW(TAGW)) bus ();

  fpaddsub_stream_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 3'b000 + {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Behavioural core: exact double sum, truncated back to single; INX flags dropped bits.
  function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    real r;
    logic [63:0] d;
    logic [10:0] e;
    r = op ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b));
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {4'b0000, |d[28:0], d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
  endfunction

  logic [36:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(bus.core_a, bus.core_b, bus.core_ctrl);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign bus.core_z     = core_pipe[LAT-1][31:0];
  assign bus.core_flags = core_pipe[LAT-1][36:32];

  // Reference: every accepted operation owes exactly one result, in acceptance order.
  rec_t exp_q[$];
  rec_t got_q[$];
  int   cyc = 0;
  int   outst = 0;
  int   max_outst = 0;
  int   ready_err = 0;
  int   zero_err = 0;
  bit   armed = 1'b0;

  always @(negedge clk) begin
    rec_t r;
    logic [36:0] res;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      outst = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (bus.in_ready !== (outst < DEPTH)) ready_err++;
      if (!bus.out_valid && (bus.out_z !== 32'd0 || bus.out_flags !== 5'd0 || bus.out_tag !== '0)) zero_err++;
      if (bus.in_valid && bus.in_ready) begin
        res = core_fn(bus.in_a, bus.in_b, bus.in_op);
        r.tag = bus.in_tag; r.z = res[31:0]; r.flags = res[36:32]; r.cyc = cyc;
        exp_q.push_back(r);
        outst++;
      end
      if (bus.out_valid && bus.out_ready) begin
        r.tag = bus.out_tag; r.z = bus.out_z; r.flags = bus.out_flags; r.cyc = cyc;
        got_q.push_back(r);
        outst--;
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    max_outst = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.in_tag = '0;
    step(2);
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst_high got=%b exp=1", bus.core_rst); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if ({bus.out_tag, bus.out_flags, bus.out_z} !== '0) begin failures++; $display("FAIL reset_out_data got=%h/%h/%h exp=0", bus.out_tag, bus.out_flags, bus.out_z); end
    checks++; if ({bus.core_ctrl, bus.core_a, bus.core_b} !== 65'd0) begin failures++; $display("FAIL reset_core_regs got=%b/%h/%h exp=0", bus.core_ctrl, bus.core_a, bus.core_b); end
    rst_n = 1'b1;
    step(1);
    checks++; if (bus.core_rst !== 1'b0) begin failures++; $display("FAIL reset_core_rst_low got=%b exp=0", bus.core_rst); end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_release got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_single_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic op, input logic [TAGW-1:0] tag, input logic [31:0] ez);
    clear_queues();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_tag = tag;
    step(1);
    bus.in_valid = 1'b0;
    step(20);
    checks++; if (exp_q.size() != 1) begin failures++; $display("FAIL %s_accepts got=%0d exp=1", nm, exp_q.size()); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL %s_results got=%0d exp=1", nm, got_q.size()); end
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      checks++; if (got_q[0].z !== ez) begin failures++; $display("FAIL %s_z got=%h exp=%h", nm, got_q[0].z, ez); end
      checks++; if (got_q[0].flags !== 5'd0) begin failures++; $display("FAIL %s_flags got=%h exp=0", nm, got_q[0].flags); end
      checks++; if (got_q[0].tag !== tag) begin failures++; $display("FAIL %s_tag got=%0d exp=%0d", nm, got_q[0].tag, tag); end
      checks++; if (got_q[0].cyc - exp_q[0].cyc != LAT + 2) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", nm, got_q[0].cyc - exp_q[0].cyc, LAT + 2); end
    end
  endtask

  task automatic compare_all(input string nm, input int n);
    checks++; if (exp_q.size() != n || got_q.size() != n) begin failures++; $display("FAIL %s_count got=%0d/%0d exp=%0d", nm, exp_q.size(), got_q.size(), n); end
    for (int i = 0; i < n && i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].tag, got_q[i].flags, got_q[i].z} !== {exp_q[i].tag, exp_q[i].flags, exp_q[i].z}) begin
        failures++;
        $display("FAIL %s_item%0d got=%h/%h/%h exp=%h/%h/%h", nm, i, got_q[i].tag, got_q[i].flags, got_q[i].z,
                 exp_q[i].tag, exp_q[i].flags, exp_q[i].z);
      end
    end
    checks++; if (ready_err != 0 || zero_err != 0) begin failures++; $display("FAIL %s_ready_zero got=%0d/%0d exp=0/0", nm, ready_err, zero_err); end
    checks++; if (max_outst > DEPTH) begin failures++; $display("FAIL %s_outstanding got=%0d exp<=%0d", nm, max_outst, DEPTH); end
  endtask

  task automatic test_backpressure();
    clear_queues();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.in_a = rand_fp(); bus.in_b = rand_fp(); bus.in_op = 1'($urandom);
      bus.in_tag = TAGW'(exp_q.size());
      step(1);
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_q.size() != DEPTH) begin failures++; $display("FAIL bp_accepts got=%0d exp=%0d", exp_q.size(), DEPTH); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_first_pop_cycle got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); end
    step(1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_credit_return got=%b exp=1", bus.in_ready); end
    step(25);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i].tag !== TAGW'(i)) begin failures++; $display("FAIL bp_tag%0d got=%0d exp=%0d", i, got_q[i].tag, i); end
    end
    compare_all("bp", DEPTH);
  endtask

  task automatic test_back_to_back();
    clear_queues();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_a = rand_fp(); bus.in_b = rand_fp(); bus.in_op = 1'($urandom); bus.in_tag = TAGW'($urandom);
      step(1);
    end
    bus.in_valid = 1'b0;
    step(20);
    compare_all("b2b", 20);
    if (got_q.size() == 20 && exp_q.size() == 20) begin
      checks++; if (got_q[19].cyc - got_q[0].cyc != 19) begin failures++; $display("FAIL b2b_throughput got=%0d exp=19", got_q[19].cyc - got_q[0].cyc); end
      checks++; if (got_q[0].cyc - exp_q[0].cyc != LAT + 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", got_q[0].cyc - exp_q[0].cyc, LAT + 2); end
    end
  endtask

  task automatic test_streaming();
    int c;
    clear_queues();
    for (c = 0; c < 4000 && !(got_q.size() == 100 && exp_q.size() == 100); c++) begin
      bus.in_valid = (exp_q.size() < 100) && 1'($urandom);
      bus.in_a = rand_fp(); bus.in_b = rand_fp(); bus.in_op = 1'($urandom); bus.in_tag = TAGW'($urandom);
      bus.out_ready = 1'($urandom);
      step(1);
    end
    bus.in_valid = 1'b0;
    checks++; if (c >= 4000) begin failures++; $display("FAIL stream_timeout got=%0d/%0d exp=100/100", exp_q.size(), got_q.size()); end
    compare_all("stream", 100);
  endtask

  task automatic test_reset_midflight();
    int seen;
    clear_queues();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_a = rand_fp(); bus.in_b = rand_fp(); bus.in_op = 1'($urandom); bus.in_tag = TAGW'(c);
      step(1);
    end
    bus.in_valid = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid !== 1'b0) seen++;
      step(1);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_out_valid got=%0d exp=0", seen); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midreset_results got=%0d exp=0", got_q.size()); end
    test_single_op("post_reset", 32'h3F800000, 32'h40000000, 1'b0, TAGW'(9), 32'h40400000);
  endtask

  task automatic test_full_pushpop();
    clear_queues();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 20) bus.out_ready = 1'b1;
      bus.in_a = rand_fp(); bus.in_b = rand_fp(); bus.in_op = 1'($urandom);
      bus.in_tag = TAGW'(exp_q.size());
      step(1);
    end
    bus.in_valid = 1'b0;
    step(40);
    checks++; if (max_outst != DEPTH) begin failures++; $display("FAIL full_peak got=%0d exp=%0d", max_outst, DEPTH); end
    compare_all("full", exp_q.size());
    checks++; if (exp_q.size() < 50) begin failures++; $display("FAIL full_accepts got=%0d exp>=50", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_op("single_add", 32'h3F800000, 32'h40000000, 1'b0, TAGW'(5), 32'h40400000);
    test_single_op("single_sub", 32'h40400000, 32'h3F800000, 1'b1, TAGW'(2), 32'h40000000);
    test_backpressure();
    test_back_to_back();
    test_streaming();
    test_reset_midflight();
    test_full_pushpop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
